// File: rtl/pipe_pkg.sv
// Shared types and per-boundary default widths for the core's handshaked pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  typedef enum logic [1:0] {
    B_IF_ID  = 2'd0,
    B_ID_EX  = 2'd1,
    B_EX_MEM = 2'd2,
    B_MEM_WB = 2'd3
  } pipe_boundary_e;

  localparam int unsigned IF_ID_DATA_W   = 64;
  localparam int unsigned IF_ID_CTRL_W   = 2;
  localparam int unsigned ID_EX_DATA_W   = 128;
  localparam int unsigned ID_EX_CTRL_W   = 12;
  localparam int unsigned EX_MEM_DATA_W  = 101;
  localparam int unsigned EX_MEM_CTRL_W  = 6;
  localparam int unsigned MEM_WB_DATA_W  = 69;
  localparam int unsigned MEM_WB_CTRL_W  = 3;
  localparam int unsigned STALL_CNT_W    = 16;

  // Payload width used when elaborating the stage at a given core boundary.
  function automatic int unsigned data_w_of(pipe_boundary_e b);
    case (b)
      B_IF_ID:  return IF_ID_DATA_W;
      B_ID_EX:  return ID_EX_DATA_W;
      B_EX_MEM: return EX_MEM_DATA_W;
      default:  return MEM_WB_DATA_W;
    endcase
  endfunction

  function automatic int unsigned ctrl_w_of(pipe_boundary_e b);
    case (b)
      B_IF_ID:  return IF_ID_CTRL_W;
      B_ID_EX:  return ID_EX_CTRL_W;
      B_EX_MEM: return EX_MEM_CTRL_W;
      default:  return MEM_WB_CTRL_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Upstream/downstream handshake bundle of one pipeline stage; names are as seen from the stage.
interface pipe_stage_hs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
);

  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              flush_i;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output valid_i, data_i, ctrl_i, ready_i, flush_i,
    input  ready_o, valid_o, data_o, ctrl_o, stall_cnt_o
  );

  modport slave (
    input  valid_i, data_i, ctrl_i, ready_i, flush_i,
    output ready_o, valid_o, data_o, ctrl_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer, flush
// and a saturating stall counter. Control field reads as zero whenever the stage is empty.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic           clk_i,
  input  logic           start_i,
  pipe_stage_hs_if.slave bus
);

  pipe_state_e       state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              valid_q;
  logic              ready_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              stall_c;

  // Stall cycles counted against the registered valid so the count tracks what downstream saw.
  always_comb begin
    stall_c = valid_q & ~bus.ready_i;
    cnt_d   = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // valid/ready are kept as their own flops so neither output has a path from the inputs.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.flush_i) begin
        state_q     <= EMPTY;
        main_ctrl_q <= '0;
        valid_q     <= 1'b0;
        ready_q     <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (bus.valid_i) begin
              main_data_q <= bus.data_i;
              main_ctrl_q <= bus.ctrl_i;
              state_q     <= FULL;
              valid_q     <= 1'b1;
            end
          end
          FULL: begin
            if (bus.valid_i && bus.ready_i) begin
              main_data_q <= bus.data_i;
              main_ctrl_q <= bus.ctrl_i;
            end else if (bus.valid_i) begin
              skid_data_q <= bus.data_i;
              skid_ctrl_q <= bus.ctrl_i;
              state_q     <= SKID;
              ready_q     <= 1'b0;
            end else if (bus.ready_i) begin
              main_ctrl_q <= '0;
              state_q     <= EMPTY;
              valid_q     <= 1'b0;
            end
          end
          SKID: begin
            if (bus.ready_i) begin
              main_data_q <= skid_data_q;
              main_ctrl_q <= skid_ctrl_q;
              state_q     <= FULL;
              ready_q     <= 1'b1;
            end
          end
          default: begin
            main_ctrl_q <= '0;
            state_q     <= EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = main_data_q;
  assign bus.ctrl_o      = main_ctrl_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Randomised and directed bench for pipe_stage_hs, checked every cycle against a
// queue-based model of the stage (two instances: 16-bit and 4-bit stall counters).
module tb_pipe_stage_hs;

  logic        clk;
  logic        rst_n;
  logic        vi;
  logic [31:0] di;
  logic [7:0]  ci;
  logic        ri;
  logic        fi;

  int unsigned n_chk;
  int unsigned n_pass;

  typedef logic [39:0] ent_t;
  ent_t        mq[$];
  logic [31:0] m_last;
  int unsigned m_cnt16;
  int unsigned m_cnt4;

  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) bus16 ();
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(8), .CNT_W(4))  bus4 ();

  assign bus16.valid_i = vi;
  assign bus16.data_i  = di;
  assign bus16.ctrl_i  = ci;
  assign bus16.ready_i = ri;
  assign bus16.flush_i = fi;
  assign bus4.valid_i  = vi;
  assign bus4.data_i   = di;
  assign bus4.ctrl_i   = ci;
  assign bus4.ready_i  = ri;
  assign bus4.flush_i  = fi;

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) u_dut16 (
    .clk_i   (clk),
    .start_i (rst_n),
    .bus     (bus16)
  );

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) u_dut4 (
    .clk_i   (clk),
    .start_i (rst_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last  = '0;
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  // Stage = FIFO of depth 2; accepts while not full, presents head while not empty.
  task automatic model_update();
    bit vld;
    bit rdy;
    vld = (mq.size() > 0);
    rdy = (mq.size() < 2);
    if (vld && !ri) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fi) begin
      mq.delete();
    end else begin
      if (vld && ri) void'(mq.pop_front());
      if (vi && rdy) mq.push_back({ci, di});
    end
    if (mq.size() > 0) m_last = mq[0][31:0];
  endtask

  task automatic compare_model();
    bit          ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    ev = (mq.size() > 0);
    ed = ev ? mq[0][31:0] : m_last;
    ec = ev ? mq[0][39:32] : 8'h00;
    chk("valid_o", 64'(bus16.valid_o), 64'(ev));
    chk("ready_o", 64'(bus16.ready_o), 64'(mq.size() < 2));
    chk("data_o", 64'(bus16.data_o), 64'(ed));
    chk("ctrl_o", 64'(bus16.ctrl_o), 64'(ec));
    chk("stall_cnt16", 64'(bus16.stall_cnt_o), 64'(m_cnt16));
    chk("stall_cnt4", 64'(bus4.stall_cnt_o), 64'(m_cnt4));
    chk("data_o_w4", 64'(bus4.data_o), 64'(ed));
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input logic [7:0] c,
                     input bit r, input bit f);
    vi = v; di = d; ci = c; ri = r; fi = f;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    vi = 1'b0; di = '0; ci = '0; ri = 1'b0; fi = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus16.valid_o), 64'd0);
    chk("rst_ready", 64'(bus16.ready_o), 64'd1);
    chk("rst_data", 64'(bus16.data_o), 64'd0);
    chk("rst_ctrl", 64'(bus16.ctrl_o), 64'd0);
    chk("rst_cnt", 64'(bus16.stall_cnt_o), 64'd0);
    rst_n = 1'b1;

    // Back-to-back stream with downstream always ready.
    cyc(1'b1, 32'h11, 8'h01, 1'b1, 1'b0);
    chk("stream_11", 64'(bus16.data_o), 64'h11);
    cyc(1'b1, 32'h22, 8'h02, 1'b1, 1'b0);
    chk("stream_22", 64'(bus16.data_o), 64'h22);
    cyc(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
    chk("stream_33", 64'(bus16.data_o), 64'h33);
    chk("stream_ready", 64'(bus16.ready_o), 64'd1);
    chk("stream_cnt", 64'(bus16.stall_cnt_o), 64'd0);

    // Skid absorb then drain.
    cyc(1'b1, 32'hA0, 8'h10, 1'b1, 1'b0);
    cyc(1'b1, 32'hA1, 8'h11, 1'b0, 1'b0);
    chk("skid_ready", 64'(bus16.ready_o), 64'd0);
    chk("skid_hold", 64'(bus16.data_o), 64'hA0);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    chk("skid_hold2", 64'(bus16.data_o), 64'hA0);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("skid_drain", 64'(bus16.data_o), 64'hA1);
    chk("skid_ctrl", 64'(bus16.ctrl_o), 64'h11);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("drain_empty", 64'(bus16.valid_o), 64'd0);
    chk("skid_cnt", 64'(bus16.stall_cnt_o), 64'd2);

    // Flush from SKID with an input on offer.
    cyc(1'b1, 32'hB0, 8'h20, 1'b1, 1'b0);
    cyc(1'b1, 32'hB1, 8'h21, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 8'h22, 1'b0, 1'b1);
    chk("flush_valid", 64'(bus16.valid_o), 64'd0);
    chk("flush_ctrl", 64'(bus16.ctrl_o), 64'd0);
    chk("flush_ready", 64'(bus16.ready_o), 64'd1);
    chk("flush_cnt", 64'(bus16.stall_cnt_o), 64'd4);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    chk("flush_after", 64'(bus16.valid_o), 64'd0);

    // Bubble masking with live control on the input.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, $urandom, 8'hFF, 1'($urandom_range(0, 1)), 1'b0);
      chk("bubble_ctrl", 64'(bus16.ctrl_o), 64'd0);
    end

    // Saturation of the narrow counter.
    cyc(1'b1, 32'hC0, 8'h30, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    chk("sat_cnt4", 64'(bus4.stall_cnt_o), 64'd15);
    chk("sat_cnt16", 64'(bus16.stall_cnt_o), 64'd24);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    chk("flush_keeps_cnt4", 64'(bus4.stall_cnt_o), 64'd15);
    chk("flush_keeps_cnt16", 64'(bus16.stall_cnt_o), 64'd24);

    // Asynchronous reset in the middle of a transfer.
    cyc(1'b1, 32'hD0, 8'h40, 1'b1, 1'b0);
    vi = 1'b1; di = 32'hD1; ci = 8'h41; ri = 1'b1; fi = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus16.valid_o), 64'd0);
    chk("arst_ready", 64'(bus16.ready_o), 64'd1);
    chk("arst_data", 64'(bus16.data_o), 64'd0);
    chk("arst_ctrl", 64'(bus16.ctrl_o), 64'd0);
    chk("arst_cnt16", 64'(bus16.stall_cnt_o), 64'd0);
    chk("arst_cnt4", 64'(bus4.stall_cnt_o), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
    chk("arst_first", 64'(bus16.data_o), 64'hD1);
    chk("arst_first_v", 64'(bus16.valid_o), 64'd1);

    // Random traffic with phases of scarce downstream readiness.
    for (int i = 0; i < 3000; i++) begin
      int unsigned rp;
      rp = ((i / 200) % 2 == 0) ? 70 : 25;
      cyc(1'($urandom_range(0, 99) < 70), $urandom, 8'($urandom),
          1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 99) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It is the next generation of the fixed per-stage pipeline registers in the 5-stage RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary becomes one instance carrying a generic data payload and a control field. The control field is zeroed whenever the stage holds a bubble, so downstream logic sees a NOP.

## Interface
Parameters:
- DATA_W, 32: width of the payload (operands, immediates, register addresses), passed unmodified.
- CTRL_W, 8: width of the control field (RegWrite, MemRead, ALUOp, ...), forced to 0 on bubbles.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- start_i  in  1  reset, asynchronous, active-low (0 = reset).
- valid_i  in  1  upstream has an entry.
- ready_o  out  1  stage can accept an entry this cycle.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control field.
- valid_o  out  1  stage holds a valid entry at its output.
- ready_i  in  1  downstream accepts the output this cycle.
- data_o  out  DATA_W  output payload.
- ctrl_o  out  CTRL_W  output control; 0 whenever valid_o = 0.
- flush_i  in  1  synchronous kill of all held entries (branch taken or exception).
- stall_cnt_o  out  CNT_W  saturating count of cycles with valid_o & ~ready_i.

## Operation
- Storage: a main register (drives the outputs) and a skid register, each holding {data, ctrl}.
- States: EMPTY (neither held), FULL (main only), SKID (main and skid).
- Handshakes: upstream transfer = valid_i & ready_o; downstream transfer = valid_o & ready_i.
- Status outputs:
  - ready_o = (state != SKID).
  - valid_o = (state != EMPTY).
- EMPTY:
  - valid_i -> load main, go to FULL.
  - otherwise stay in EMPTY.
- FULL:
  - valid_i & ready_i -> load main from the input, stay in FULL.
  - valid_i & ~ready_i -> load skid from the input, go to SKID.
  - ~valid_i & ready_i -> go to EMPTY.
  - ~valid_i & ~ready_i -> hold.
- SKID:
  - ready_o = 0; no input is accepted.
  - ready_i -> main <= skid, go to FULL.
  - otherwise hold.
- Flush:
  - flush_i has highest priority; the next state is EMPTY regardless of the handshakes.
  - An input offered in the flush cycle is dropped.
  - The output in the flush cycle still counts as transferred if ready_i = 1.
- Bubble masking:
  - ctrl_o = valid_o ? main.ctrl : 0.
  - data_o keeps its last loaded value when EMPTY (don't-care, but deterministic).
- Stall counter:
  - Increments on every cycle with valid_o & ~ready_i.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset (start_i = 0, asynchronous):
  - State is EMPTY, so valid_o = 0 and ready_o = 1.
  - data_o = 0, ctrl_o = 0, stall_cnt_o = 0; the skid register = 0.
- Latency: an input accepted at edge N appears on data_o/valid_o after edge N. This is 1 cycle, the same as the legacy stage registers.
- Throughput: 1 entry per cycle while ready_i stays high.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o. ready_o depends only on the state register.
- After ready_i falls while FULL, exactly one more input is absorbed (into skid). ready_o then drops the following cycle.
- Entry order is preserved; no entry is duplicated or lost except by flush.
- Reset asserted mid-transfer: contents are discarded immediately. No partial entry appears after start_i rises.
- flush_i and start_i both active: reset wins. Outcome is identical (EMPTY).

## Structure
- Shared package pipe_pkg holds:
  - the state enum typedef pipe_state_e {EMPTY, FULL, SKID};
  - default width constants for each core stage boundary (IF_ID_DATA_W, ID_EX_DATA_W, ID_EX_CTRL_W, ...).
- Single module; no sub-module. The skid path is small enough to keep inline.
- The core instantiates one pipe_stage_hs per stage boundary. Hazard/branch logic drives flush_i and ready_i.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with ready_i = 1 -> data_o shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after input; ready_o stays 1; stall_cnt_o = 0.
- In FULL holding 0xA0, drop ready_i while offering 0xA1 -> ready_o = 0 next cycle and data_o stays 0xA0. Raise ready_i -> outputs 0xA0 then 0xA1; no loss or duplication; stall_cnt_o increments once per stalled cycle.
- In SKID (0xB0 main, 0xB1 skid), assert flush_i with valid_i = 1, data_i = 0xB2 -> next cycle valid_o = 0, ctrl_o = 0, ready_o = 1; 0xB0, 0xB1 and 0xB2 never appear.
- Hold ready_i = 0 with CNT_W = 4 for 20 cycles -> stall_cnt_o saturates at 15 and does not wrap.
- Pull start_i low for half a cycle in the middle of a transfer -> outputs go to reset values immediately, without waiting for a clock edge. After release, the first new input appears with 1-cycle latency.
- ctrl_i = 0xFF with valid_i = 0 for several cycles -> ctrl_o stays 0 throughout.
